// File: rtl/icache_refill_ctrl_pkg.sv
// Shared CPU defines for the I-cache refill path: line geometry, FSM states, address helpers.
package icache_refill_ctrl_pkg;

  localparam int LINE_WORDS = 16;
  localparam int OFFSET_W   = 6;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int LINE_BITS  = LINE_WORDS * 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [WORD_W-1:0] word_sel(input logic [31:0] addr);
    return addr[OFFSET_W-1:2];
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_line_buf.sv
// Refill line buffer: LINE_WORDS x 32 registers, one write port, one word read, full-line read.
module icache_line_buf
  import icache_refill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORD_W-1:0]     waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [WORD_W-1:0]     raddr_i,
  output logic [31:0]           rdata_o,
  output logic [LINE_BITS-1:0]  line_o
);

  logic [31:0] mem_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  always_comb begin
    line_o = {LINE_BITS{1'b0}};
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_o[i*32 +: 32] = mem_q[i];
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill engine: one AXI read per miss, line refill for cached misses.
// Optional macro ICACHE_CRITICAL_WORD_EN returns the requested word as soon as its beat arrives.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  input  logic                  miss_uncached,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_word,
  output logic                  busy,
  output logic                  refill_we,
  output logic [INDEX_W-1:0]    refill_index,
  output logic [TAG_W-1:0]      refill_tag,
  output logic [LINE_BITS-1:0]  refill_line,
  output logic                  cache_ena,
  output logic                  inst_ren,
  output logic [31:0]           inst_araddr,
  output logic                  inst_arvalid,
  input  logic                  inst_arready,
  input  logic [31:0]           inst_rdata,
  input  logic                  inst_rvalid,
  input  logic                  inst_rlast
);

  state_e              state_q;
  logic [31:0]         addr_q;
  logic                uncached_q;
  logic                cancel_q;
  logic [WORD_W-1:0]   cnt_q;
  logic                resp_valid_q;
  logic [31:0]         resp_word_q;
  logic                busy_q;
  logic                refill_we_q;
  logic                cache_ena_q;
  logic                inst_ren_q;
  logic                inst_arvalid_q;
  logic [31:0]         inst_araddr_q;

  logic                beat_s;
  logic                cancel_s;
  logic [WORD_W-1:0]   rd_idx_s;
  logic [31:0]         rd_word_s;
  logic [LINE_BITS-1:0] line_s;

  assign beat_s   = (state_q == ST_R) && inst_rvalid;
  // A flush in the same cycle as the deciding edge must already count as cancelled.
  assign cancel_s = cancel_q || flush;
  assign rd_idx_s = uncached_q ? {WORD_W{1'b0}} : word_sel(addr_q);

  icache_line_buf u_line_buf (
    .clk     (clk),
    .we_i    (beat_s),
    .waddr_i (cnt_q),
    .wdata_i (inst_rdata),
    .raddr_i (rd_idx_s),
    .rdata_o (rd_word_s),
    .line_o  (line_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= 32'd0;
      uncached_q     <= 1'b0;
      cancel_q       <= 1'b0;
      cnt_q          <= {WORD_W{1'b0}};
      resp_valid_q   <= 1'b0;
      resp_word_q    <= 32'd0;
      busy_q         <= 1'b0;
      refill_we_q    <= 1'b0;
      cache_ena_q    <= 1'b0;
      inst_ren_q     <= 1'b0;
      inst_arvalid_q <= 1'b0;
      inst_araddr_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      refill_we_q  <= 1'b0;
      if (flush && (state_q != ST_IDLE)) begin
        cancel_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (miss_req) begin
            state_q        <= ST_AR;
            addr_q         <= miss_addr;
            uncached_q     <= miss_uncached;
            cancel_q       <= 1'b0;
            busy_q         <= 1'b1;
            inst_ren_q     <= 1'b1;
            inst_arvalid_q <= 1'b1;
            cache_ena_q    <= !miss_uncached;
            inst_araddr_q  <= miss_uncached ? miss_addr : line_base(miss_addr);
          end
        end
        ST_AR: begin
          if (inst_arready) begin
            state_q        <= ST_R;
            inst_arvalid_q <= 1'b0;
            cnt_q          <= {WORD_W{1'b0}};
          end
        end
        ST_R: begin
          if (inst_rvalid) begin
            cnt_q <= cnt_q + {{(WORD_W-1){1'b0}}, 1'b1};
            if (inst_rlast) begin
              inst_ren_q  <= 1'b0;
              cache_ena_q <= 1'b0;
              if (uncached_q) begin
                state_q      <= ST_DONE;
                resp_valid_q <= !cancel_s;
                // The single beat is written at this same edge, so bypass the buffer.
                resp_word_q  <= (cnt_q == {WORD_W{1'b0}}) ? inst_rdata : rd_word_s;
              end else begin
                state_q     <= ST_FILL;
                refill_we_q <= !cancel_s;
              end
            end
          end
        end
        ST_FILL: begin
          state_q <= ST_DONE;
`ifdef ICACHE_CRITICAL_WORD_EN
          resp_valid_q <= 1'b0;
`else
          resp_valid_q <= !cancel_s;
          resp_word_q  <= rd_word_s;
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_CRITICAL_WORD_EN
  logic crit_hit_s;
  assign crit_hit_s = beat_s && !uncached_q && (cnt_q == word_sel(addr_q)) && !cancel_s;
  assign resp_valid = resp_valid_q || crit_hit_s;
  assign resp_word  = crit_hit_s ? inst_rdata : resp_word_q;
`else
  assign resp_valid = resp_valid_q;
  assign resp_word  = resp_word_q;
`endif

  assign busy         = busy_q;
  assign refill_we    = refill_we_q;
  assign refill_index = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign refill_tag   = addr_q[31:OFFSET_W+INDEX_W];
  assign refill_line  = refill_we_q ? line_s : {LINE_BITS{1'b0}};
  assign cache_ena    = cache_ena_q;
  assign inst_ren     = inst_ren_q;
  assign inst_araddr  = inst_araddr_q;
  assign inst_arvalid = inst_arvalid_q;

endmodule
